// File: rtl/rhythm_pkg.sv
// Shared types and point values for the rhythm-game judging stage.
package rhythm_pkg;

  typedef enum logic [1:0] {J_NONE, J_PERFECT, J_GOOD, J_MISS} judge_t;

  typedef enum logic [1:0] {IDLE, PLAY, DONE} play_state_t;

  localparam int unsigned PTS_PERFECT = 2;
  localparam int unsigned PTS_GOOD    = 1;

endpackage

// File: rtl/note_lane.sv
// Scrolling note column: row 0 is the target row, notes enter at the top on tick.
module note_lane #(
  parameter int unsigned ROWS = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  input  logic            spawn,
  input  logic            clear0,
  input  logic            clear1,
  input  logic            clear_all,
  output logic [ROWS-1:0] lane,
  output logic            drop
);

  logic [ROWS-1:0] r_lane;
  logic [ROWS-1:0] w_kept;

  // Hits clear their row before the shift so a graded note never also drops.
  always_comb begin
    w_kept    = r_lane;
    w_kept[0] = r_lane[0] & ~clear0;
    w_kept[1] = r_lane[1] & ~clear1;
  end

  assign drop = tick & w_kept[0];
  assign lane = r_lane;

  always_ff @(posedge clk) begin
    if (reset || clear_all) begin
      r_lane <= '0;
    end else if (tick) begin
      r_lane <= {spawn, w_kept[ROWS-1:1]};
    end else begin
      r_lane <= w_kept;
    end
  end

endmodule

// File: rtl/hit_judge.sv
// Per-lane judging: grades presses against the note column, keeps score/combo/misses.
module hit_judge
  import rhythm_pkg::*;
#(
  parameter int unsigned ROWS     = 8,
  parameter int unsigned SCORE_W  = 10,
  parameter int unsigned COMBO_W  = 7,
  parameter int unsigned MAX_MISS = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               press,
  input  logic               tick,
  input  logic               spawn,
  output logic [ROWS-1:0]    lane,
  output judge_t             judge,
  output logic               judge_valid,
  output logic [SCORE_W-1:0] score,
  output logic [COMBO_W-1:0] combo,
  output logic [COMBO_W-1:0] best_combo,
  output logic               playing,
  output logic               game_over
);

  localparam int unsigned MW = $clog2(MAX_MISS + 1);

  play_state_t        r_state;
  judge_t             r_judge;
  logic               r_judge_valid;
  logic               r_game_over;
  logic [SCORE_W-1:0] r_score;
  logic [COMBO_W-1:0] r_combo;
  logic [COMBO_W-1:0] r_best;
  logic [MW-1:0]      r_misses;

  logic               w_in_play, w_press, w_tick;
  logic               w_perfect, w_good, w_bad, w_drop;
  logic               w_hit, w_miss, w_final, w_clear_all;
  logic [MW-1:0]      w_miss_next;
  logic [SCORE_W-1:0] w_pts;
  logic [SCORE_W:0]   w_sum;
  logic [SCORE_W-1:0] w_score_next;
  logic [COMBO_W-1:0] w_combo_inc;

  always_comb begin
    w_in_play   = (r_state == PLAY);
    w_press     = press & w_in_play;
    w_tick      = tick & w_in_play;
    w_perfect   = w_press & lane[0];
    w_good      = w_press & ~lane[0] & lane[1];
    w_bad       = w_press & ~lane[0] & ~lane[1];
    w_hit       = w_perfect | w_good;
    // A bad press implies lane[0]=0, so it can never coincide with a drop.
    w_miss      = w_bad | w_drop;
    w_miss_next = r_misses + 1'b1;
    w_final     = w_miss && (w_miss_next == MW'(MAX_MISS));
    w_clear_all = (start & ~w_in_play) | w_final;

    w_pts        = w_perfect ? SCORE_W'(PTS_PERFECT) : SCORE_W'(PTS_GOOD);
    w_sum        = {1'b0, r_score} + {1'b0, w_pts};
    w_score_next = w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];
    w_combo_inc  = (r_combo == '1) ? r_combo : r_combo + 1'b1;
  end

  note_lane #(.ROWS(ROWS)) u_lane (
    .clk       (clk),
    .reset     (reset),
    .tick      (w_tick),
    .spawn     (spawn),
    .clear0    (w_perfect),
    .clear1    (w_good),
    .clear_all (w_clear_all),
    .lane      (lane),
    .drop      (w_drop)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_judge       <= J_NONE;
      r_judge_valid <= 1'b0;
      r_game_over   <= 1'b0;
      r_score       <= '0;
      r_combo       <= '0;
      r_best        <= '0;
      r_misses      <= '0;
    end else begin
      r_judge       <= J_NONE;
      r_judge_valid <= 1'b0;
      r_game_over   <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state  <= PLAY;
            r_score  <= '0;
            r_combo  <= '0;
            r_best   <= '0;
            r_misses <= '0;
          end
        end
        PLAY: begin
          if (w_hit) begin
            r_judge_valid <= 1'b1;
            r_judge       <= w_perfect ? J_PERFECT : J_GOOD;
            r_score       <= w_score_next;
            r_combo       <= w_combo_inc;
            if (w_combo_inc > r_best) r_best <= w_combo_inc;
          end else if (w_miss) begin
            r_judge_valid <= 1'b1;
            r_judge       <= J_MISS;
            r_combo       <= '0;
            r_misses      <= w_miss_next;
            if (w_final) begin
              r_state     <= DONE;
              r_game_over <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign judge       = r_judge;
  assign judge_valid = r_judge_valid;
  assign score       = r_score;
  assign combo       = r_combo;
  assign best_combo  = r_best;
  assign playing     = (r_state == PLAY);
  assign game_over   = r_game_over;

endmodule
